// File: rtl/bifrost_glue_if.sv
// CPU-side bus bundle for the 6502 board glue: address, direction and status strobes.
// The data bus stays a plain inout on the glue block because it is a tristate pad.
interface bifrost_glue_if;
    logic [18:0] addr;
    logic        rw;
    logic        vecpull;
    logic        mlock;
    logic        sync;

    modport master (
        output addr,
        output rw,
        output vecpull,
        output mlock,
        output sync
    );

    modport slave (
        input addr,
        input rw,
        input vecpull,
        input mlock,
        input sync
    );
endinterface

// File: rtl/bifrost_glue.sv
// 6502 board glue: decode, phi2, reset hold-off, IRQ aggregation, register page and SPI flash master.
// Define BIFROST_IRQ_MASK_EN to implement the IRQ_MASK register; otherwise all sources are enabled.
module bifrost_glue #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned RESET_CYCLES = 64,
    parameter logic [7:0]  IO_PAGE      = 8'hDE
) (
    input  logic          i_clock,
    input  logic          i_reset,
    bifrost_glue_if.slave i_bus,
    inout  wire  [7:0]    io_data,
    input  logic          i_via1_irq,
    input  logic          i_via2_irq,
    input  logic          i_uart_irq,
    input  logic          i_uart_txbirq,
    input  logic          i_uart_rxbirq,
    input  logic          i_uart_txairq,
    input  logic          i_uart_rxairq,
    input  logic          i_flash_miso,
    output logic          o_flash_sck,
    output logic          o_flash_mosi,
    output logic          o_flash_cs_n,
    output logic          o_cpu_phi2,
    output logic          o_cpu_resb,
    output logic          o_cpu_irqb,
    output logic          o_ram_ce_n,
    output logic          o_ram_oe_n,
    output logic          o_ram_we_n,
    output logic          o_via1_cs_n,
    output logic          o_via2_cs_n,
    output logic          o_uart_cs_n
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);

    typedef enum logic [0:0] {SpiIdle, SpiShift} spi_state_e;

    // ---------------------------------------------------------------- phi2
    logic [DivW-1:0] r_div;
    logic            r_phi2;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div  <= '0;
            r_phi2 <= 1'b0;
        end else if (r_div == DivLast) begin
            r_div  <= '0;
            r_phi2 <= ~r_phi2;
        end else begin
            r_div <= r_div + DivW'(1);
        end
    end

    // ---------------------------------------------------------------- CPU reset hold-off
    logic [RstW-1:0] r_rst_cnt;
    logic            r_resb;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rst_cnt <= '0;
            r_resb    <= 1'b0;
        end else if (!r_resb) begin
            r_rst_cnt <= r_rst_cnt + RstW'(1);
            if (r_rst_cnt == RstLast) begin
                r_resb <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- address decode
    logic       w_io;
    logic       w_ram;
    logic       w_sel_via1;
    logic       w_sel_via2;
    logic       w_sel_uart;
    logic       w_sel_int;
    logic [2:0] w_reg;
    logic       w_last_high;
    logic       w_wr;
    logic       w_drive;
    logic [7:0] w_din;
    logic [7:0] w_rdata;

    assign w_io       = (i_bus.addr[18:16] == 3'd0) && (i_bus.addr[15:8] == IO_PAGE);
    assign w_ram      = ~w_io;
    assign w_sel_via1 = w_io && (i_bus.addr[7:4] == 4'h0);
    assign w_sel_via2 = w_io && (i_bus.addr[7:4] == 4'h1);
    assign w_sel_uart = w_io && (i_bus.addr[7:4] == 4'h2);
    assign w_sel_int  = w_io && (i_bus.addr[7:4] == 4'h3) && !i_bus.addr[3];
    assign w_reg      = i_bus.addr[2:0];

    // Register writes land on the clock that ends the phi2-high phase.
    assign w_last_high = r_phi2 && (r_div == DivLast);
    assign w_wr        = w_sel_int && !i_bus.rw && w_last_high;
    assign w_drive     = w_sel_int && i_bus.rw && r_phi2;
    assign w_din       = io_data;
    assign io_data     = w_drive ? w_rdata : 8'bzzzz_zzzz;

    assign o_ram_ce_n  = ~w_ram;
    assign o_ram_oe_n  = ~(w_ram & i_bus.rw & r_phi2);
    assign o_ram_we_n  = ~(w_ram & ~i_bus.rw & r_phi2);
    assign o_via1_cs_n = ~w_sel_via1;
    assign o_via2_cs_n = ~w_sel_via2;
    assign o_uart_cs_n = ~w_sel_uart;

    // ---------------------------------------------------------------- CTRL and CPU status
    logic       r_cs_n;
    logic [2:0] r_cpu_stat;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cs_n     <= 1'b1;
            r_cpu_stat <= 3'b000;
        end else begin
            r_cpu_stat <= {i_bus.vecpull, i_bus.mlock, i_bus.sync};
            if (w_wr && (w_reg == 3'd0)) begin
                r_cs_n <= w_din[0];
            end
        end
    end

    // ---------------------------------------------------------------- IRQ aggregation
    logic [6:0] w_irq_n;
    logic [6:0] w_mask;
    logic [6:0] r_irq_s1;
    logic [6:0] r_pend;
    logic       r_irqb;

    assign w_irq_n = {i_uart_rxairq, i_uart_txairq, i_uart_rxbirq, i_uart_txbirq,
                      i_uart_irq, i_via2_irq, i_via1_irq};

`ifdef BIFROST_IRQ_MASK_EN
    logic [6:0] r_mask;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mask <= 7'h7F;
        end else if (w_wr && (w_reg == 3'd4)) begin
            r_mask <= w_din[6:0];
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = 7'h7F;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_irq_s1 <= 7'h00;
            r_pend   <= 7'h00;
            r_irqb   <= 1'b1;
        end else begin
            r_irq_s1 <= ~w_irq_n;
            r_pend   <= r_irq_s1;
            r_irqb   <= ~|(r_pend & w_mask);
        end
    end

    // ---------------------------------------------------------------- SPI master, mode 0
    spi_state_e r_spi_state;
    logic       r_sck;
    logic       r_mosi;
    logic [7:0] r_shift;
    logic [3:0] r_spi_cnt;
    logic [7:0] r_rx;
    logic       w_busy;

    assign w_busy = (r_spi_state == SpiShift);

    // The shift register sends from the top and collects MISO at the bottom.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_spi_state <= SpiIdle;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_shift     <= 8'h00;
            r_spi_cnt   <= 4'd0;
            r_rx        <= 8'h00;
        end else begin
            case (r_spi_state)
                SpiIdle: begin
                    if (w_wr && (w_reg == 3'd1)) begin
                        r_shift     <= w_din;
                        r_mosi      <= w_din[7];
                        r_spi_cnt   <= 4'd0;
                        r_spi_state <= SpiShift;
                    end
                end
                SpiShift: begin
                    r_sck     <= ~r_sck;
                    r_spi_cnt <= r_spi_cnt + 4'd1;
                    if (!r_sck) begin
                        r_shift <= {r_shift[6:0], i_flash_miso};
                    end else if (r_spi_cnt == 4'd15) begin
                        r_rx        <= r_shift;
                        r_mosi      <= 1'b0;
                        r_spi_state <= SpiIdle;
                    end else begin
                        r_mosi <= r_shift[7];
                    end
                end
                default: r_spi_state <= SpiIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- register read mux
    always_comb begin
        w_rdata = 8'h00;
        case (w_reg)
            3'd0:    w_rdata = {7'b0, r_cs_n};
            3'd1:    w_rdata = r_rx;
            3'd2:    w_rdata = {7'b0, w_busy};
            3'd3:    w_rdata = {1'b0, r_pend};
            3'd4:    w_rdata = {1'b0, w_mask};
            3'd5:    w_rdata = {5'b0, r_cpu_stat};
            3'd6:    w_rdata = 8'hB1;
            default: w_rdata = 8'h00;
        endcase
    end

    assign o_flash_sck  = r_sck;
    assign o_flash_mosi = r_mosi;
    assign o_flash_cs_n = r_cs_n;
    assign o_cpu_phi2   = r_phi2;
    assign o_cpu_resb   = r_resb;
    assign o_cpu_irqb   = r_irqb;

endmodule

// File: tb/tb_bifrost_glue.sv
// Directed bench for bifrost_glue: table of decode/register-read vectors plus hand-written
// sequences for reset hold-off, IRQ latency, SPI transfers and reset during a transfer.
module tb_bifrost_glue;

    logic       r_clk = 1'b0;
    logic       r_reset;
    logic       r_via1_irq, r_via2_irq, r_uart_irq, r_txb, r_rxb, r_txa, r_rxa;
    logic       r_miso;
    logic [7:0] r_tb_data;
    logic       r_tb_oe;
    wire  [7:0] w_data;
    logic       w_sck, w_mosi, w_cs_n, w_phi2, w_resb, w_irqb;
    logic       w_ram_ce_n, w_ram_oe_n, w_ram_we_n, w_via1_cs_n, w_via2_cs_n, w_uart_cs_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bifrost_glue_if u_bus ();

    assign w_data = r_tb_oe ? r_tb_data : 8'bzzzz_zzzz;

    bifrost_glue dut (
        .i_clock      (r_clk),
        .i_reset      (r_reset),
        .i_bus        (u_bus.slave),
        .io_data      (w_data),
        .i_via1_irq   (r_via1_irq),
        .i_via2_irq   (r_via2_irq),
        .i_uart_irq   (r_uart_irq),
        .i_uart_txbirq(r_txb),
        .i_uart_rxbirq(r_rxb),
        .i_uart_txairq(r_txa),
        .i_uart_rxairq(r_rxa),
        .i_flash_miso (r_miso),
        .o_flash_sck  (w_sck),
        .o_flash_mosi (w_mosi),
        .o_flash_cs_n (w_cs_n),
        .o_cpu_phi2   (w_phi2),
        .o_cpu_resb   (w_resb),
        .o_cpu_irqb   (w_irqb),
        .o_ram_ce_n   (w_ram_ce_n),
        .o_ram_oe_n   (w_ram_oe_n),
        .o_ram_we_n   (w_ram_we_n),
        .o_via1_cs_n  (w_via1_cs_n),
        .o_via2_cs_n  (w_via2_cs_n),
        .o_uart_cs_n  (w_uart_cs_n)
    );

    always #5 r_clk = ~r_clk;
    always @(posedge r_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [18:0] addr;
        logic        rw;
        logic        hi;
        logic [5:0]  exp_cs;   // {ram_ce_n, ram_oe_n, ram_we_n, via1_cs_n, via2_cs_n, uart_cs_n}
        logic        exp_drv;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_phi2(input logic level);
        int n = 0;
        while (w_phi2 !== level && n < 20) begin
            @(negedge r_clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_phi2 actual=%0b expected=%0b", w_phi2, level);
        end
    endtask

    // Returns on the first negedge after the commit edge (phi2 just fell).
    task automatic cpu_write(input logic [18:0] a, input logic [7:0] d);
        @(negedge r_clk);
        u_bus.addr = a;
        u_bus.rw   = 1'b0;
        r_tb_data  = d;
        r_tb_oe    = 1'b1;
        wait_phi2(1'b1);
        wait_phi2(1'b0);
        u_bus.rw   = 1'b1;
        r_tb_oe    = 1'b0;
        u_bus.addr = 19'h0DE40;
    endtask

    task automatic cpu_read(input logic [18:0] a, output logic [7:0] d, output logic drv);
        @(negedge r_clk);
        u_bus.addr = a;
        u_bus.rw   = 1'b1;
        wait_phi2(1'b1);
        #1;
        d   = w_data;
        drv = dut.w_drive;
    endtask

    task automatic read_check(input string name, input logic [18:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       drv;
        cpu_read(a, d, drv);
        check({name, "_drv"}, drv, 1'b1);
        check(name, d, exp);
    endtask

    // via1 toggles every clock; cpu_irqb must mirror the input three clocks later unless masked.
    task automatic irq_toggle(input string name, input logic masked);
        logic hist[24];
        logic exp;
        for (int m = 0; m < 24; m++) begin
            @(negedge r_clk);
            exp = masked ? 1'b1 : ((m >= 3) ? hist[m-3] : 1'b1);
            check($sformatf("%s_m%0d", name, m), w_irqb, exp);
            hist[m]    = m[0];
            r_via1_irq = hist[m];
        end
        r_via1_irq = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] tx;
        logic       drv;
        logic       mask_en;
        int         t0;
        int         n;

`ifdef BIFROST_IRQ_MASK_EN
        mask_en = 1'b1;
`else
        mask_en = 1'b0;
`endif

        vecs[0]  = '{19'h0CAFE, 1'b1, 1'b1, 6'b001111, 1'b0, 8'h00};
        vecs[1]  = '{19'h0CAFE, 1'b0, 1'b1, 6'b010111, 1'b0, 8'h00};
        vecs[2]  = '{19'h0CAFE, 1'b1, 1'b0, 6'b011111, 1'b0, 8'h00};
        vecs[3]  = '{19'h0DE00, 1'b1, 1'b1, 6'b111011, 1'b0, 8'h00};
        vecs[4]  = '{19'h0DE10, 1'b1, 1'b1, 6'b111101, 1'b0, 8'h00};
        vecs[5]  = '{19'h0DE2F, 1'b1, 1'b1, 6'b111110, 1'b0, 8'h00};
        vecs[6]  = '{19'h1DE10, 1'b1, 1'b1, 6'b001111, 1'b0, 8'h00};
        vecs[7]  = '{19'h0DD10, 1'b1, 1'b1, 6'b001111, 1'b0, 8'h00};
        vecs[8]  = '{19'h0DE36, 1'b1, 1'b1, 6'b111111, 1'b1, 8'hB1};
        vecs[9]  = '{19'h0DE37, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h00};
        vecs[10] = '{19'h0DE30, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h01};
        vecs[11] = '{19'h0DE31, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h00};
        vecs[12] = '{19'h0DE32, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h00};
        vecs[13] = '{19'h0DE33, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h00};
        vecs[14] = '{19'h0DE34, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h7F};
        vecs[15] = '{19'h0DE35, 1'b1, 1'b1, 6'b111111, 1'b1, 8'h06};
        vecs[16] = '{19'h0DE3E, 1'b1, 1'b1, 6'b111111, 1'b0, 8'h00};
        vecs[17] = '{19'h0DE40, 1'b1, 1'b1, 6'b111111, 1'b0, 8'h00};
        vecs[18] = '{19'h0DEF3, 1'b1, 1'b1, 6'b111111, 1'b0, 8'h00};
        vecs[19] = '{19'h0DE36, 1'b1, 1'b0, 6'b111111, 1'b0, 8'h00};
        vecs[20] = '{19'h0DE36, 1'b0, 1'b1, 6'b111111, 1'b0, 8'h00};

        r_reset      = 1'b1;
        u_bus.addr   = 19'h0DE40;
        u_bus.rw     = 1'b1;
        u_bus.vecpull = 1'b1;
        u_bus.mlock  = 1'b1;
        u_bus.sync   = 1'b0;
        {r_via1_irq, r_via2_irq, r_uart_irq, r_txb, r_rxb, r_txa, r_rxa} = 7'h7F;
        r_miso       = 1'b0;
        r_tb_data    = 8'h00;
        r_tb_oe      = 1'b0;

        // Reset values and hold-off
        repeat (5) @(posedge r_clk);
        @(negedge r_clk);
        check("rst_phi2", w_phi2, 1'b0);
        check("rst_resb", w_resb, 1'b0);
        check("rst_irqb", w_irqb, 1'b1);
        check("rst_cs_n", w_cs_n, 1'b1);
        check("rst_sck", w_sck, 1'b0);
        check("rst_mosi", w_mosi, 1'b0);
        check("rst_selects", {w_ram_ce_n, w_ram_oe_n, w_ram_we_n, w_via1_cs_n, w_via2_cs_n,
                              w_uart_cs_n}, 6'b111111);
        check("rst_drive", dut.w_drive, 1'b0);
        r_reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge r_clk);
            check($sformatf("phi2_c%0d", k), w_phi2, (k / 2) % 2);
            check($sformatf("resb_c%0d", k), w_resb, (k == 64) ? 1'b1 : 1'b0);
        end

        // Decode and register-read table
        for (int i = 0; i < 21; i++) begin
            @(negedge r_clk);
            wait_phi2(vecs[i].hi);
            u_bus.addr = vecs[i].addr;
            u_bus.rw   = vecs[i].rw;
            #1;
            check($sformatf("v%0d_cs", i), {w_ram_ce_n, w_ram_oe_n, w_ram_we_n, w_via1_cs_n,
                                            w_via2_cs_n, w_uart_cs_n}, vecs[i].exp_cs);
            check($sformatf("v%0d_drv", i), dut.w_drive, vecs[i].exp_drv);
            if (vecs[i].exp_drv) begin
                check($sformatf("v%0d_data", i), w_data, vecs[i].exp_data);
            end
        end
        u_bus.rw   = 1'b1;
        u_bus.addr = 19'h0DE40;

        // IRQ status and latency
        @(negedge r_clk);
        r_via2_irq = 1'b0;
        repeat (3) @(negedge r_clk);
        check("irq_via2_irqb", w_irqb, 1'b0);
        read_check("irq_stat_via2", 19'h0DE33, 8'h02);
        r_via2_irq = 1'b1;
        repeat (4) @(negedge r_clk);
        check("irq_via2_clear", w_irqb, 1'b1);
        irq_toggle("irq_tog", 1'b0);
        repeat (4) @(negedge r_clk);
        cpu_write(19'h0DE34, 8'h7E);
        read_check("irq_mask_rd", 19'h0DE34, mask_en ? 8'h7E : 8'h7F);
        irq_toggle("irq_masked", mask_en);
        cpu_write(19'h0DE34, 8'h7F);

        // SPI transfer of 0x03 with MISO held high
        cpu_write(19'h0DE30, 8'h00);
        check("ctrl_cs_low", w_cs_n, 1'b0);
        r_miso = 1'b1;
        tx = 8'h03;
        cpu_write(19'h0DE31, tx);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge r_clk);
            check($sformatf("spi_busy_c%0d", k), dut.w_busy, 1'b1);
            check($sformatf("spi_sck_c%0d", k), w_sck, (k % 2 == 0) ? 1'b1 : 1'b0);
            if (k % 2 == 1) begin
                check($sformatf("spi_mosi_c%0d", k), w_mosi, tx[7 - (k - 1) / 2]);
            end
        end
        @(negedge r_clk);
        check("spi_busy_end", dut.w_busy, 1'b0);
        check("spi_sck_end", w_sck, 1'b0);
        read_check("spi_rx_ff", 19'h0DE31, 8'hFF);
        read_check("spi_stat_idle", 19'h0DE32, 8'h00);

        // A second SPI_DATA write during a transfer must not extend it
        r_miso = 1'b0;
        cpu_write(19'h0DE31, 8'hA5);
        t0 = cyc;
        cpu_write(19'h0DE31, 8'h5A);
        n = 0;
        while (dut.w_busy && n < 40) begin
            @(negedge r_clk);
            n++;
        end
        check("spi_ignored_len", cyc - t0, 16);
        read_check("spi_rx_00", 19'h0DE31, 8'h00);

        // Reset during a transfer
        r_miso = 1'b1;
        cpu_write(19'h0DE31, 8'h0F);
        repeat (5) @(negedge r_clk);
        check("mid_busy", dut.w_busy, 1'b1);
        check("mid_cs_low", w_cs_n, 1'b0);
        r_reset = 1'b1;
        @(negedge r_clk);
        check("mid_rst_cs_n", w_cs_n, 1'b1);
        check("mid_rst_sck", w_sck, 1'b0);
        check("mid_rst_busy", dut.w_busy, 1'b0);
        check("mid_rst_resb", w_resb, 1'b0);
        check("mid_rst_phi2", w_phi2, 1'b0);
        r_reset = 1'b0;
        repeat (10) @(negedge r_clk);
        check("mid_rst_holdoff", w_resb, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
